mram_arbiter: RTL and testbench

MRAM_ARBITER -- requirements
Module: mram_arbiter

---
 rtl/mram_arbiter.sv | 142 ++++++++++++++
 tb/tb_mram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mram_arbiter.sv
// Two-port MRAM arbiter: grants one requester at a time and runs a fixed-timing async SRAM-style cycle.
// Define MRAM_RR_ARB_EN for round-robin arbitration; fixed priority (port 0 wins) otherwise.
module mram_arbiter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_rw,
  input  logic        req1_rw,
  input  logic [19:0] req0_addr,
  input  logic [19:0] req1_addr,
  input  logic [15:0] req0_wdata,
  input  logic [15:0] req1_wdata,
  input  logic [1:0]  req0_be_n,
  input  logic [1:0]  req1_be_n,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_rdata,
  output logic [19:0] mram_addr,
  output logic [15:0] mram_dq_out,
  output logic        mram_dq_oe,
  input  logic [15:0] mram_dq_in,
  output logic        chip_en,
  output logic        write_en,
  output logic        out_en,
  output logic        lower_byte_en,
  output logic        upper_byte_en,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       rw_q;
  logic       id_q;
  logic [1:0] be_q;
  logic       last_grant;
  logic       grant_sel;
  logic       hs;

  // grant_sel only matters when some port is valid; otherwise it idles on last_grant
  always_comb begin
`ifdef MRAM_RR_ARB_EN
    if (req0_valid && req1_valid) grant_sel = ~last_grant;
    else if (req0_valid)          grant_sel = 1'b0;
    else if (req1_valid)          grant_sel = 1'b1;
    else                          grant_sel = last_grant;
`else
    if (req0_valid)      grant_sel = 1'b0;
    else if (req1_valid) grant_sel = 1'b1;
    else                 grant_sel = last_grant;
`endif
  end

  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_sel;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant_sel;
  assign hs         = req0_ready | req1_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd1) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      mram_addr   <= '0;
      mram_dq_out <= '0;
      rsp_rdata   <= '0;
      rsp_id      <= 1'b0;
      rw_q        <= 1'b0;
      id_q        <= 1'b0;
      be_q        <= 2'b11;
      cnt         <= '0;
    end else begin
      if (hs) begin
        rw_q        <= grant_sel ? req1_rw    : req0_rw;
        mram_addr   <= grant_sel ? req1_addr  : req0_addr;
        mram_dq_out <= grant_sel ? req1_wdata : req0_wdata;
        be_q        <= grant_sel ? req1_be_n  : req0_be_n;
        id_q        <= grant_sel;
        last_grant  <= grant_sel;
      end
      if (state == SETUP)       cnt <= WAIT_LD;
      else if (state == ACCESS) cnt <= cnt - 4'd1;
      // read data is sampled on the edge that closes the final access cycle
      if (state == ACCESS && cnt == 4'd1 && !rw_q) begin
        rsp_rdata <= mram_dq_in;
        rsp_id    <= id_q;
      end
    end
  end

  always_comb begin
    chip_en       = 1'b1;
    write_en      = 1'b1;
    out_en        = 1'b1;
    lower_byte_en = 1'b1;
    upper_byte_en = 1'b1;
    mram_dq_oe    = 1'b0;
    rsp_valid     = 1'b0;
    busy          = (state != IDLE);
    case (state)
      SETUP: begin
        chip_en    = 1'b0;
        mram_dq_oe = rw_q;
      end
      ACCESS: begin
        chip_en       = 1'b0;
        write_en      = ~rw_q;
        out_en        = rw_q;
        lower_byte_en = be_q[0];
        upper_byte_en = be_q[1];
        mram_dq_oe    = rw_q;
      end
      HOLD: begin
        mram_dq_oe = rw_q;
        rsp_valid  = ~rw_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mram_arbiter.sv
// Bench for mram_arbiter: directed scenarios plus random traffic against a cycle-offset reference model.
module tb_mram_arbiter;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0, req0_rw = 0, req1_rw = 0;
  logic [19:0] req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_wdata = 0, req1_wdata = 0, mram_dq_in = 0;
  logic [1:0]  req0_be_n = 0, req1_be_n = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, mram_dq_oe;
  logic [15:0] rsp_rdata, mram_dq_out;
  logic [19:0] mram_addr;
  logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en, busy;

  always #5 clk = ~clk;

  mram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_rw(req0_rw), .req1_rw(req1_rw),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_be_n(req0_be_n), .req1_be_n(req1_be_n),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .mram_addr(mram_addr), .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe),
    .mram_dq_in(mram_dq_in),
    .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: one outstanding transaction, described by its handshake cycle and latched fields
  bit          m_active = 0;
  int          m_t = 0;
  bit          m_rw = 0, m_id = 0, m_last = 1;
  logic [19:0] m_addr = 0;
  logic [15:0] m_wdata = 0, m_rdata = 0;
  logic [1:0]  m_be = 2'b11;
  logic        m_rid = 0;

  int n_we, n_ce, n_oe, n_dqoe, n_rsp, n_lb, n_ub, hs_cyc, rsp_cyc;
  int grants[$];

  function automatic int pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) begin
`ifdef MRAM_RR_ARB_EN
      return last ? 0 : 1;
`else
      return 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_tallies();
    n_we = 0; n_ce = 0; n_oe = 0; n_dqoe = 0; n_rsp = 0; n_lb = 0; n_ub = 0;
    hs_cyc = -1; rsp_cyc = -1;
  endtask

  task automatic check_cycle();
    int  k, g;
    logic e_ce, e_we, e_oe, e_lb, e_ub, e_dqoe, e_rsp, e_r0, e_r1;
    k = m_active ? cyc - m_t : 0;
    e_ce = 1; e_we = 1; e_oe = 1; e_lb = 1; e_ub = 1;
    e_dqoe = 0; e_rsp = 0; e_r0 = 0; e_r1 = 0;
    if (m_active) begin
      e_dqoe = m_rw;
      if (k <= W + 1) e_ce = 0;
      if (k >= 2 && k <= W + 1) begin
        e_we = !m_rw; e_oe = m_rw; e_lb = m_be[0]; e_ub = m_be[1];
      end
      if (k == W + 2) e_rsp = !m_rw;
    end else if (rst_n) begin
      g = pick(req0_valid, req1_valid, m_last);
      e_r0 = (g == 0); e_r1 = (g == 1);
    end
    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("busy", 32'(busy), 32'(m_active));
    chk("chip_en", 32'(chip_en), 32'(e_ce));
    chk("write_en", 32'(write_en), 32'(e_we));
    chk("out_en", 32'(out_en), 32'(e_oe));
    chk("lower_byte_en", 32'(lower_byte_en), 32'(e_lb));
    chk("upper_byte_en", 32'(upper_byte_en), 32'(e_ub));
    chk("mram_dq_oe", 32'(mram_dq_oe), 32'(e_dqoe));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("mram_addr", 32'(mram_addr), 32'(m_addr));
    if (e_dqoe) chk("mram_dq_out", 32'(mram_dq_out), 32'(m_wdata));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("strobe_exclusive", 32'(!write_en && !out_en), 32'(0));
    n_we += int'(!write_en); n_ce += int'(!chip_en); n_oe += int'(!out_en);
    n_dqoe += int'(mram_dq_oe); n_rsp += int'(rsp_valid);
    n_lb += int'(!lower_byte_en); n_ub += int'(!upper_byte_en);
    if (req0_ready) grants.push_back(0);
    if (req1_ready) grants.push_back(1);
    if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) hs_cyc = cyc;
    if (rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
  endtask

  // check the current cycle, advance one clock edge, then advance the model
  task automatic tick();
    int g;
    #1;
    check_cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_active = 0; m_last = 1; m_addr = 0; m_wdata = 0; m_rdata = 0; m_rid = 0;
    end else if (m_active) begin
      if (cyc - m_t == W + 1 && !m_rw) begin
        m_rdata = mram_dq_in; m_rid = m_id;
      end
      if (cyc - m_t == W + 2) m_active = 0;
    end else begin
      g = pick(req0_valid, req1_valid, m_last);
      if (g == 0) begin
        m_rw = req0_rw; m_addr = req0_addr; m_wdata = req0_wdata; m_be = req0_be_n; m_id = 0;
      end else if (g == 1) begin
        m_rw = req1_rw; m_addr = req1_addr; m_wdata = req1_wdata; m_be = req1_be_n; m_id = 1;
      end
      if (g >= 0) begin
        m_active = 1; m_t = cyc; m_last = (g == 1);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic scramble();
    req0_addr = 20'($urandom); req1_addr = 20'($urandom);
    req0_wdata = 16'($urandom); req1_wdata = 16'($urandom);
    req0_rw = 1'($urandom); req1_rw = 1'($urandom);
    req0_be_n = 2'($urandom); req1_be_n = 2'($urandom);
    mram_dq_in = 16'($urandom);
  endtask

  int exp_order[4];

  initial begin
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    clear_tallies();
    tick(); tick();
    rst_n = 1;
    tick();

    // port 0 write, all bytes
    clear_tallies();
    req0_valid = 1; req0_rw = 1; req0_addr = 20'h12345; req0_wdata = 16'hBEEF; req0_be_n = 2'b00;
    tick();
    req0_valid = 0; req0_addr = 20'h0; req0_wdata = 16'h0;
    repeat (W + 3) tick();
    chk("wr_write_en_cycles", 32'(n_we), 32'(W));
    chk("wr_chip_en_cycles", 32'(n_ce), 32'(W + 1));
    chk("wr_dq_oe_cycles", 32'(n_dqoe), 32'(W + 2));
    chk("wr_rsp_count", 32'(n_rsp), 32'(0));

    // port 1 read at top address
    clear_tallies();
    req1_valid = 1; req1_rw = 0; req1_addr = 20'hFFFFF; req1_be_n = 2'b00; mram_dq_in = 16'hA5C3;
    tick();
    req1_valid = 0;
    repeat (W + 3) tick();
    chk("rd_rsp_latency", 32'(rsp_cyc - hs_cyc), 32'(W + 2));
    chk("rd_rsp_count", 32'(n_rsp), 32'(1));
    chk("rd_rsp_id", 32'(rsp_id), 32'(1));
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h0000A5C3);

    // both ports continuously valid for four transactions
    rst_n = 0; tick(); rst_n = 1;
    grants.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4 * (W + 3); i++) begin
      scramble();
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();
`ifdef MRAM_RR_ARB_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("grant_count", 32'(grants.size()), 32'(4));
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("grant_%0d", i), 32'(grants[i]), 32'(exp_order[i]));

    // reset during the second access cycle of a read
    clear_tallies();
    req0_valid = 1; req0_rw = 0; req0_addr = 20'h00ABC; req0_be_n = 2'b00;
    tick();
    req0_valid = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (W + 2) tick();
    chk("abort_rsp_count", 32'(n_rsp), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));

    // read with only the lower byte enabled
    clear_tallies();
    req1_valid = 1; req1_rw = 0; req1_addr = 20'h54321; req1_be_n = 2'b10; mram_dq_in = 16'h1234;
    tick();
    req1_valid = 0;
    repeat (W + 3) tick();
    chk("be10_lower_cycles", 32'(n_lb), 32'(W));
    chk("be10_upper_cycles", 32'(n_ub), 32'(0));

    // random traffic with occasional reset and dropped requests
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      scramble();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
